// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   PC_W          : program-counter / ROM address width
//   NOP_INSTR_DEF : default bubble encoding injected into IF/ID
//   state_e       : run controller states
package fetch_pkg;

  localparam int unsigned PC_W = 8;
  localparam logic [8:0]  NOP_INSTR_DEF = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_stage_pc_counter.sv
// Program-counter register with synchronous reset to START_PC,
// load (highest priority), increment with natural wrap, else hold.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i
//   load_val_i : value to load
//   inc_i      : increment by one (ignored while loading)
//   pc_o       : current PC
module pc_counter
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= START_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register and IDLE/RUN/HALT controller.
//   clock, reset      : clock, synchronous active-high reset
//   start             : begin execution from IDLE or HALT
//   stall             : freeze PC and IF/ID
//   MEX_branch_*      : branch feedback (ctrl, taken, absolute target)
//   MEX_jmp_*         : jump feedback (ctrl, absolute target)
//   MEX_done_ctrl     : program end reached in MEX
//   imem_addr/data    : instruction ROM interface (combinational read)
//   ID_instr/pc/valid : IF/ID register contents
//   flush             : kill ID/MEX this cycle (done or redirect)
//   running, halted   : controller state flags
//   cycle_count       : saturating count of RUN cycles since last start
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    START_PC  = 8'h00,
  parameter int unsigned        INSTR_W   = 9,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               MEX_branch_ctrl,
  input  logic               MEX_branch_taken,
  input  logic [PC_W-1:0]    MEX_branch_val,
  input  logic               MEX_jmp_ctrl,
  input  logic [PC_W-1:0]    MEX_jmp_val,
  input  logic               MEX_done_ctrl,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ID_instr,
  output logic [PC_W-1:0]    ID_pc,
  output logic               ID_valid,
  output logic               flush,
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   id_instr_q, id_instr_d;
  logic [PC_W-1:0]      id_pc_q, id_pc_d;
  logic                 id_valid_q, id_valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 pc_load, pc_inc;
  logic [PC_W-1:0]      pc_load_val, pc;
  logic                 redirect;
  logic [PC_W-1:0]      target;

  pc_counter #(
    .START_PC (START_PC)
  ) u_pc (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // Jump takes precedence over a simultaneous taken branch.
  assign redirect = (state_q == RUN) &&
                    (MEX_jmp_ctrl || (MEX_branch_ctrl && MEX_branch_taken));
  assign target   = MEX_jmp_ctrl ? MEX_jmp_val : MEX_branch_val;

  always_comb begin
    state_d     = state_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    cnt_d       = cnt_q;
    pc_load     = 1'b0;
    pc_load_val = START_PC;
    pc_inc      = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d     = RUN;
          pc_load     = 1'b1;
          pc_load_val = START_PC;
          id_instr_d  = NOP_INSTR;
          id_pc_d     = '0;
          id_valid_d  = 1'b0;
          cnt_d       = '0;
        end
      end
      RUN: begin
        // Counts every RUN edge, stalls and the halting edge included.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (MEX_done_ctrl) begin
          state_d    = HALT;
          id_instr_d = NOP_INSTR;
          id_pc_d    = '0;
          id_valid_d = 1'b0;
          flush      = 1'b1;
        end else if (redirect) begin
          pc_load     = 1'b1;
          pc_load_val = target;
          id_instr_d  = NOP_INSTR;
          id_pc_d     = '0;
          id_valid_d  = 1'b0;
          flush       = 1'b1;
        end else if (!stall) begin
          id_instr_d = imem_data;
          id_pc_d    = pc;
          id_valid_d = 1'b1;
          pc_inc     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc;
  assign ID_instr    = id_instr_q;
  assign ID_pc       = id_pc_q;
  assign ID_valid    = id_valid_q;
  assign running     = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural model compared every
// cycle, directed scenarios with literal expectations, random stimulus.
module tb_fetch_stage;

  logic       clock = 1'b0;
  logic       reset, start, stall;
  logic       MEX_branch_ctrl, MEX_branch_taken, MEX_jmp_ctrl, MEX_done_ctrl;
  logic [7:0] MEX_branch_val, MEX_jmp_val;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] ID_instr;
  logic [7:0] ID_pc;
  logic       ID_valid, flush, running, halted;
  logic [15:0] cycle_count;

  logic [8:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign imem_data = rom[imem_addr];

  fetch_stage #(
    .START_PC  (8'h00),
    .INSTR_W   (9),
    .NOP_INSTR (9'h000),
    .CNT_W     (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .stall            (stall),
    .MEX_branch_ctrl  (MEX_branch_ctrl),
    .MEX_branch_taken (MEX_branch_taken),
    .MEX_branch_val   (MEX_branch_val),
    .MEX_jmp_ctrl     (MEX_jmp_ctrl),
    .MEX_jmp_val      (MEX_jmp_val),
    .MEX_done_ctrl    (MEX_done_ctrl),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .ID_instr         (ID_instr),
    .ID_pc            (ID_pc),
    .ID_valid         (ID_valid),
    .flush            (flush),
    .running          (running),
    .halted           (halted),
    .cycle_count      (cycle_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 = idle, 1 = running, 2 = halted
  int         m_mode;
  logic [7:0] m_pc, m_idpc;
  logic [8:0] m_idinstr;
  bit         m_idvalid;
  int         m_cnt;
  bit         m_known = 0;

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      m_mode = 0; m_pc = 8'h00; m_idinstr = 9'h000; m_idpc = 8'h00;
      m_idvalid = 0; m_cnt = 0; m_known = 1;
    end else if (m_known) begin
      if (m_mode != 1) begin
        if (start) begin
          m_mode = 1; m_pc = 8'h00; m_idinstr = 9'h000; m_idpc = 8'h00;
          m_idvalid = 0; m_cnt = 0;
        end
      end else begin
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (MEX_done_ctrl) begin
          m_mode = 2; m_idinstr = 9'h000; m_idvalid = 0;
        end else if (MEX_jmp_ctrl) begin
          m_pc = MEX_jmp_val; m_idinstr = 9'h000; m_idvalid = 0;
        end else if (MEX_branch_ctrl && MEX_branch_taken) begin
          m_pc = MEX_branch_val; m_idinstr = 9'h000; m_idvalid = 0;
        end else if (!stall) begin
          m_idinstr = rom[m_pc]; m_idpc = m_pc; m_idvalid = 1;
          m_pc = 8'((int'(m_pc) + 1) % 256);
        end
      end
    end
  end

  function automatic bit m_flush();
    return (m_mode == 1) &&
           (MEX_done_ctrl || MEX_jmp_ctrl || (MEX_branch_ctrl && MEX_branch_taken));
  endfunction

  // Compare process: inputs change at the negedge, checks run 2 time units later.
  always @(negedge clock) begin
    #2;
    if (m_known) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("ID_valid", 32'(ID_valid), 32'(m_idvalid));
      chk("ID_instr", 32'(ID_instr), 32'(m_idinstr));
      if (m_idvalid) chk("ID_pc", 32'(ID_pc), 32'(m_idpc));
      chk("flush", 32'(flush), 32'(m_flush()));
      chk("running", 32'(running), 32'(m_mode == 1));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
    end
  end

  task automatic clear_in();
    start = 0; stall = 0; MEX_branch_ctrl = 0; MEX_branch_taken = 0;
    MEX_branch_val = 8'h00; MEX_jmp_ctrl = 0; MEX_jmp_val = 8'h00; MEX_done_ctrl = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h00);
    chk({tag, "_instr"}, 32'(ID_instr), 32'h000);
    chk({tag, "_idpc"}, 32'(ID_pc), 32'h00);
    chk({tag, "_valid"}, 32'(ID_valid), 32'h0);
    chk({tag, "_flush"}, 32'(flush), 32'h0);
    chk({tag, "_running"}, 32'(running), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_count"}, 32'(cycle_count), 32'h0);
  endtask

  logic [8:0]  lit [4];
  logic [15:0] cc;
  logic [8:0]  held;

  initial begin
    lit[0] = 9'h011; lit[1] = 9'h022; lit[2] = 9'h033; lit[3] = 9'h044;
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
    for (int i = 0; i < 4; i++) rom[i] = lit[i];
    clear_in();
    reset = 1;
    repeat (2) @(negedge clock);
    chk_reset_vals("rst0");

    // Start and first four fetches
    reset = 0; start = 1;
    @(negedge clock); start = 0;
    chk("entry_running", 32'(running), 32'h1);
    chk("entry_valid", 32'(ID_valid), 32'h0);
    chk("entry_addr", 32'(imem_addr), 32'h00);
    chk("entry_count", 32'(cycle_count), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("fetch_instr", 32'(ID_instr), 32'(lit[k]));
      chk("fetch_pc", 32'(ID_pc), 32'(k));
      chk("fetch_valid", 32'(ID_valid), 32'h1);
    end
    @(negedge clock);
    chk("pc05", 32'(imem_addr), 32'h05);

    // Stall for three cycles at pc 05
    cc = cycle_count; held = ID_instr; stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_flush", 32'(flush), 32'h0);
      @(negedge clock);
      chk("stall_addr", 32'(imem_addr), 32'h05);
      chk("stall_instr", 32'(ID_instr), 32'(held));
    end
    stall = 0;
    chk("stall_count", 32'(cycle_count), 32'(cc + 16'd3));
    @(negedge clock);
    chk("resume_idpc", 32'(ID_pc), 32'h05);
    chk("resume_addr", 32'(imem_addr), 32'h06);

    // Taken branch overriding stall
    stall = 1; MEX_branch_ctrl = 1; MEX_branch_taken = 1; MEX_branch_val = 8'h40;
    #1 chk("br_flush", 32'(flush), 32'h1);
    @(negedge clock); clear_in();
    chk("br_addr", 32'(imem_addr), 32'h40);
    chk("br_valid", 32'(ID_valid), 32'h0);
    @(negedge clock);
    chk("br_idpc", 32'(ID_pc), 32'h40);
    chk("br_valid2", 32'(ID_valid), 32'h1);

    // Not-taken branch
    MEX_branch_ctrl = 1; MEX_branch_taken = 0; MEX_branch_val = 8'h10;
    #1 chk("nt_flush", 32'(flush), 32'h0);
    @(negedge clock); clear_in();
    chk("nt_addr", 32'(imem_addr), 32'h42);
    chk("nt_idpc", 32'(ID_pc), 32'h41);

    // Jump beats branch
    MEX_jmp_ctrl = 1; MEX_jmp_val = 8'h80;
    MEX_branch_ctrl = 1; MEX_branch_taken = 1; MEX_branch_val = 8'h20;
    @(negedge clock); clear_in();
    chk("jmp_wins", 32'(imem_addr), 32'h80);

    // Done with simultaneous jump
    MEX_done_ctrl = 1; MEX_jmp_ctrl = 1; MEX_jmp_val = 8'h33;
    #1 chk("done_flush", 32'(flush), 32'h1);
    @(negedge clock); clear_in();
    chk("done_halted", 32'(halted), 32'h1);
    chk("done_running", 32'(running), 32'h0);
    chk("done_addr", 32'(imem_addr), 32'h80);
    cc = cycle_count;
    stall = 1; MEX_jmp_ctrl = 1; MEX_jmp_val = 8'h55;
    #1 chk("halt_flush", 32'(flush), 32'h0);
    @(negedge clock); clear_in();
    chk("halt_addr", 32'(imem_addr), 32'h80);
    chk("halt_count", 32'(cycle_count), 32'(cc));
    start = 1;
    @(negedge clock); start = 0;
    chk("restart_addr", 32'(imem_addr), 32'h00);
    chk("restart_count", 32'(cycle_count), 32'h0);
    chk("restart_running", 32'(running), 32'h1);

    // PC wrap
    MEX_jmp_ctrl = 1; MEX_jmp_val = 8'hFE;
    @(negedge clock); clear_in();
    chk("wrap_fe", 32'(imem_addr), 32'hFE);
    @(negedge clock);
    @(negedge clock);
    chk("wrap_00", 32'(imem_addr), 32'h00);
    chk("wrap_idpc", 32'(ID_pc), 32'hFF);

    // Reset mid-RUN after a redirect
    MEX_jmp_ctrl = 1; MEX_jmp_val = 8'h10;
    @(negedge clock);
    MEX_jmp_val = 8'h77; reset = 1;
    @(negedge clock); reset = 0; clear_in();
    #1 chk_reset_vals("rst_mid");

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      start            = ($urandom_range(0, 19) == 0);
      stall            = ($urandom_range(0, 3) == 0);
      MEX_branch_ctrl  = ($urandom_range(0, 7) == 0);
      MEX_branch_taken = $urandom_range(0, 1) == 1;
      MEX_branch_val   = 8'($urandom);
      MEX_jmp_ctrl     = ($urandom_range(0, 19) == 0);
      MEX_jmp_val      = 8'($urandom);
      MEX_done_ctrl    = ($urandom_range(0, 49) == 0);
      @(negedge clock);
    end
    clear_in(); reset = 0;

    // Saturation: long RUN with no done
    reset = 1;
    @(negedge clock); reset = 0; start = 1;
    @(negedge clock); start = 0;
    repeat (70000) @(negedge clock);
    chk("sat_count", 32'(cycle_count), 32'hFFFF);
    chk("sat_running", 32'(running), 32'h1);

    @(negedge clock);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
